// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control unit: state encodings,
// ALU operation codes, condition codes, flag bit positions and the condition evaluator.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECUTER = ST_EXECUTER,
        S_EXECUTEI = ST_EXECUTEI,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Encoding 4'hF (unconditional space) never executes in this core.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Bundle between the control unit, the instruction register fields and the datapath controls.
interface mc_control_unit_if #(parameter int ALUCTL_W = 2);
    logic [3:0]          Cond;
    logic [1:0]          Op;
    logic [5:0]          Funct;
    logic [3:0]          Rd;
    logic [3:0]          ALUFlags;
    logic                PCWrite;
    logic                MemWrite;
    logic                RegWrite;
    logic                IRWrite;
    logic                AdrSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ResultSrc;
    logic [1:0]          ImmSrc;
    logic [1:0]          RegSrc;
    logic [ALUCTL_W-1:0] ALUControl;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/mc_control_unit_cond_logic.sv
// Condition evaluation: NZCV flag register, registered condition result and
// gating of the PC, register-file and memory write enables.
module cond_logic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       next_pc,
    input  logic       reg_w,
    input  logic       mem_w,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);

    logic [3:0] flags_r;
    logic       cond_ex_s;
    logic       cond_ex_r;

    assign cond_ex_s = cond_eval(cond, flags_r);

    // NZ and CV halves update independently, only when the instruction executes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else begin
            if (flag_w[1] & cond_ex_s) begin
                flags_r[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] & cond_ex_s) begin
                flags_r[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Condition result held for the writeback / branch cycle that follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_r <= 1'b0;
        end else begin
            cond_ex_r <= cond_ex_s;
        end
    end

    assign pc_write  = next_pc | (pcs & cond_ex_r);
    assign reg_write = reg_w & cond_ex_r;
    assign mem_write = mem_w & cond_ex_r;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder and immediate/register
// source selection; condition handling lives in cond_logic.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 2
)(
    input  logic                 clk,
    input  logic                 reset,
    mc_control_unit_if.master    bus
);

    state_t     state_r;
    state_t     state_next_s;
    logic       ir_write_s;
    logic       next_pc_s;
    logic       reg_w_s;
    logic       mem_w_s;
    logic       branch_s;
    logic       alu_op_s;
    logic       adr_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_ctl_s;
    logic [1:0] flag_w_s;
    logic       pcs_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_next_s = S_FETCH;
        ir_write_s   = 1'b0;
        next_pc_s    = 1'b0;
        reg_w_s      = 1'b0;
        mem_w_s      = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = 1'b0;
        adr_src_s    = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        result_src_s = 2'b00;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                next_pc_s    = 1'b1;
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                case (bus.Op)
                    2'b00: begin
                        if (bus.Funct[5]) begin
                            state_next_s = S_EXECUTEI;
                        end else begin
                            state_next_s = S_EXECUTER;
                        end
                    end
                    2'b01:   state_next_s = S_MEMADR;
                    2'b10:   state_next_s = S_BRANCH;
                    default: state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b_s = 2'b01;
                if (bus.Funct[0]) begin
                    state_next_s = S_MEMREAD;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_s    = 1'b1;
                state_next_s = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_w_s      = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_w_s      = 1'b1;
                state_next_s = S_FETCH;
            end
            S_EXECUTER: begin
                alu_op_s     = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b_s  = 2'b01;
                alu_op_s     = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w_s      = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                branch_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // ALU decoder; CMP (1010) subtracts, unlisted commands fall back to ADD.
    always_comb begin
        alu_ctl_s = ALU_ADD;
        flag_w_s  = 2'b00;
        if (alu_op_s) begin
            case (bus.Funct[4:1])
                4'b0100: alu_ctl_s = ALU_ADD;
                4'b0010: alu_ctl_s = ALU_SUB;
                4'b1010: alu_ctl_s = ALU_SUB;
                4'b0000: alu_ctl_s = ALU_AND;
                4'b1100: alu_ctl_s = ALU_ORR;
                default: alu_ctl_s = ALU_ADD;
            endcase
            flag_w_s[1] = bus.Funct[0];
            flag_w_s[0] = bus.Funct[0] & ((alu_ctl_s == ALU_ADD) | (alu_ctl_s == ALU_SUB));
        end else begin
            alu_ctl_s = ALU_ADD;
            flag_w_s  = 2'b00;
        end
    end

    assign pcs_s = ((bus.Rd == 4'd15) & reg_w_s) | branch_s;

    cond_logic u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.Cond),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w_s),
        .pcs       (pcs_s),
        .next_pc   (next_pc_s),
        .reg_w     (reg_w_s),
        .mem_w     (mem_w_s),
        .pc_write  (bus.PCWrite),
        .reg_write (bus.RegWrite),
        .mem_write (bus.MemWrite)
    );

    assign bus.IRWrite    = ir_write_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
    assign bus.ALUControl = ALUCTL_W'(alu_ctl_s);

endmodule
